// File: rtl/de2_115_timer_sequencer_pkg.sv
// Shared types and constants for the interval-timer sequencer.
// Register map, control bits and FSM states.
package de2_115_timer_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    CLR_STAT,
    WR_STOP,
    SNAP_WR,
    SNAP_RL,
    SNAP_RH,
    SNAP_CAP
  } state_t;

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_CONTROL  = 3'd1;
  localparam logic [2:0] A_PERIOD_L = 3'd2;
  localparam logic [2:0] A_PERIOD_H = 3'd3;
  localparam logic [2:0] A_SNAP_L   = 3'd4;
  localparam logic [2:0] A_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int MIN_PERIOD_DEF = 16;
  localparam int TICK_W_DEF     = 16;

  function automatic logic [15:0] ctrl_word(
    input logic ito,
    input logic cont,
    input logic start,
    input logic stop
  );
    ctrl_word             = '0;
    ctrl_word[CTRL_ITO]   = ito;
    ctrl_word[CTRL_CONT]  = cont;
    ctrl_word[CTRL_START] = start;
    ctrl_word[CTRL_STOP]  = stop;
  endfunction

endpackage

// File: rtl/de2_115_timer_sequencer_if.sv
// Avalon-MM link between the sequencer and the interval timer.
// Master drives the bus; slave returns read data and IRQ.
interface de2_115_timer_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/de2_115_timer_sequencer.sv
// Avalon-MM master sequencing the interval timer:
// program/start, IRQ service with tick, stop and snapshot.
module de2_115_timer_sequencer
  import de2_115_timer_sequencer_pkg::*;
#(
  parameter int TICK_W     = TICK_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              start_req,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              cfg_err,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  de2_115_timer_sequencer_if.master tm
);

  state_t      state, state_n;
  logic [31:0] period_m1;
  logic        cont;
  logic        stop_pend, stop_pend_n;
  logic        snap_pend, snap_pend_n;
  logic        from_run, from_run_n;
  logic [15:0] snap_lo;
  logic        start_ok, start_bad;

  always_comb begin
    start_ok  = (state == IDLE) && start_req &&
                (cfg_period >= 32'(MIN_PERIOD));
    start_bad = (state == IDLE) && start_req && !start_ok;
  end

  always_comb begin
    state_n     = state;
    stop_pend_n = stop_pend | stop_req;
    snap_pend_n = snap_pend | snap_req;
    from_run_n  = from_run;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = WR_PL;
        end else if (!start_req && snap_req) begin
          state_n    = SNAP_WR;
          from_run_n = 1'b0;
        end
      end
      WR_PL:   state_n = WR_PH;
      WR_PH:   state_n = WR_CTRL;
      WR_CTRL: state_n = RUN;
      RUN: begin
        if (tm.irq) begin
          state_n = CLR_STAT;
        end else if (stop_pend_n) begin
          state_n     = WR_STOP;
          stop_pend_n = 1'b0;
        end else if (snap_pend_n) begin
          state_n     = SNAP_WR;
          snap_pend_n = 1'b0;
          from_run_n  = 1'b1;
        end
      end
      CLR_STAT: state_n = cont ? RUN : IDLE;
      WR_STOP:  state_n = IDLE;
      SNAP_WR:  state_n = SNAP_RL;
      SNAP_RL:  state_n = SNAP_RH;
      SNAP_RH:  state_n = SNAP_CAP;
      SNAP_CAP: state_n = from_run ? RUN : IDLE;
      default:  state_n = IDLE;
    endcase
    // Requests only survive while a RUN is still ahead.
    if (state == IDLE || state_n == IDLE) begin
      stop_pend_n = 1'b0;
      snap_pend_n = 1'b0;
    end
  end

  always_comb begin
    tm.address    = '0;
    tm.chipselect = 1'b0;
    tm.write_n    = 1'b1;
    tm.writedata  = '0;
    if (!reset) begin
      unique case (state)
        WR_PL: begin
          tm.chipselect = 1'b1;
          tm.write_n    = 1'b0;
          tm.address    = A_PERIOD_L;
          tm.writedata  = period_m1[15:0];
        end
        WR_PH: begin
          tm.chipselect = 1'b1;
          tm.write_n    = 1'b0;
          tm.address    = A_PERIOD_H;
          tm.writedata  = period_m1[31:16];
        end
        WR_CTRL: begin
          tm.chipselect = 1'b1;
          tm.write_n    = 1'b0;
          tm.address    = A_CONTROL;
          tm.writedata  = ctrl_word(1'b1, cont, 1'b1, 1'b0);
        end
        CLR_STAT: begin
          tm.chipselect = 1'b1;
          tm.write_n    = 1'b0;
          tm.address    = A_STATUS;
        end
        WR_STOP: begin
          tm.chipselect = 1'b1;
          tm.write_n    = 1'b0;
          tm.address    = A_CONTROL;
          tm.writedata  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        end
        SNAP_WR: begin
          tm.chipselect = 1'b1;
          tm.write_n    = 1'b0;
          tm.address    = A_SNAP_L;
        end
        SNAP_RL: begin
          tm.chipselect = 1'b1;
          tm.address    = A_SNAP_L;
        end
        SNAP_RH: begin
          tm.chipselect = 1'b1;
          tm.address    = A_SNAP_H;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign tick = (state == CLR_STAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      period_m1  <= '0;
      cont       <= 1'b0;
      stop_pend  <= 1'b0;
      snap_pend  <= 1'b0;
      from_run   <= 1'b0;
      snap_lo    <= '0;
      tick_count <= '0;
      cfg_err    <= 1'b0;
      snap_valid <= 1'b0;
      snap_value <= '0;
    end else begin
      state      <= state_n;
      stop_pend  <= stop_pend_n;
      snap_pend  <= snap_pend_n;
      from_run   <= from_run_n;
      cfg_err    <= start_bad;
      snap_valid <= (state == SNAP_CAP);
      if (start_ok) begin
        period_m1  <= cfg_period - 32'd1;
        cont       <= cfg_continuous;
        tick_count <= '0;
      end else if (state == CLR_STAT) begin
        tick_count <= tick_count + 1'b1;
      end
      // Read data lags the address by one cycle.
      if (state == SNAP_RH) snap_lo <= tm.readdata;
      if (state == SNAP_CAP) snap_value <= {tm.readdata, snap_lo};
    end
  end

endmodule

// File: tb/tb_de2_115_timer_sequencer.sv
// Bench for de2_115_timer_sequencer with a behavioural timer
// slave and scoreboards for bus accesses and snapshots.
module tb_de2_115_timer_sequencer;
  import de2_115_timer_sequencer_pkg::*;

  localparam int CLK_NS = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_period;
  logic        cfg_continuous;
  logic        start_req;
  logic        stop_req;
  logic        snap_req;
  logic        busy;
  logic        tick;
  logic [15:0] tick_count;
  logic        cfg_err;
  logic        snap_valid;
  logic [31:0] snap_value;

  always #(CLK_NS/2) clk = ~clk;

  de2_115_timer_sequencer_if tm();

  de2_115_timer_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .start_req      (start_req),
    .stop_req       (stop_req),
    .snap_req       (snap_req),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count),
    .cfg_err        (cfg_err),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value),
    .tm             (tm)
  );

  // Timer slave model: counts P..0, raises irq at 0.
  logic        run = 1'b0, mcont = 1'b0, mirq = 1'b0;
  logic [15:0] pl = '0, ph = '0, rdata = '0;
  logic [31:0] cnt = '0, msnap = '0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_val = '0;
  logic        wr;

  assign tm.irq      = mirq;
  assign tm.readdata = rdata;
  assign wr = tm.chipselect && !tm.write_n;

  always @(posedge clk) begin
    if (tm.chipselect && tm.write_n)
      rdata <= (tm.address == 3'd4) ? msnap[15:0] :
               (tm.address == 3'd5) ? msnap[31:16] : 16'h0;
    if (wr && tm.address == 3'd0) mirq <= 1'b0;
    if (wr && tm.address == 3'd2) pl <= tm.writedata;
    if (wr && tm.address == 3'd3) ph <= tm.writedata;
    if (wr && tm.address == 3'd4) msnap <= cnt;
    if (wr && tm.address == 3'd1 && tm.writedata[2]) begin
      run   <= 1'b1;
      mcont <= tm.writedata[1];
      cnt   <= {ph, pl};
    end else if (wr && tm.address == 3'd1 && tm.writedata[3]) begin
      run <= 1'b0;
    end else if (poke_en) begin
      cnt <= poke_val;
    end else if (run) begin
      if (cnt == 0) begin
        mirq <= 1'b1;
        if (mcont) cnt <= {ph, pl};
        else run <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  typedef struct {
    bit          rd;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_op_t;

  bus_op_t     exp_q[$];
  logic [31:0] snap_q[$];
  time         tick_times[$];
  int          cfg_err_seen = 0;
  int          errors = 0;
  int          checks = 0;
  time         t_start;

  task automatic push_op(input bit rd, input logic [2:0] a,
                         input logic [15:0] d);
    bus_op_t e;
    e.rd = rd; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_start(input logic [31:0] p, input bit c);
    logic [31:0] pm;
    pm = p - 1;
    push_op(0, 3'd2, pm[15:0]);
    push_op(0, 3'd3, pm[31:16]);
    push_op(0, 3'd1, c ? 16'h0007 : 16'h0005);
  endtask

  task automatic push_snap();
    push_op(0, 3'd4, 16'h0);
    push_op(1, 3'd4, 16'h0);
    push_op(1, 3'd5, 16'h0);
  endtask

  task automatic do_start(input logic [31:0] p, input bit c);
    @(negedge clk);
    t_start = $time;
    cfg_period = p; cfg_continuous = c; start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
  endtask

  task automatic do_stop();
    push_op(0, 3'd1, 16'h0008);
    @(negedge clk); stop_req = 1'b1;
    @(negedge clk); stop_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n, input int budget);
    for (int i = 0; i < budget && tick_times.size() < n; i++)
      @(negedge clk);
  endtask

  task automatic wait_snap(input int budget);
    for (int i = 0; i < budget && snap_q.size() != 0; i++)
      @(negedge clk);
  endtask

  task automatic monitor();
    bus_op_t e;
    logic [31:0] es;
    forever begin
      @(negedge clk);
      if (tm.chipselect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: got wn=%0b a=%0d d=%h, required no access",
                   tm.write_n, tm.address, tm.writedata);
        end else begin
          e = exp_q.pop_front();
          if (tm.write_n !== e.rd || tm.address !== e.addr ||
              tm.writedata !== e.data) begin
            errors++;
            $display("FAIL bus_op: got wn=%0b a=%0d d=%h, required wn=%0b a=%0d d=%h",
                     tm.write_n, tm.address, tm.writedata,
                     e.rd, e.addr, e.data);
          end
        end
      end
      if (tick) tick_times.push_back($time);
      if (cfg_err) cfg_err_seen++;
      if (snap_valid) begin
        checks++;
        if (snap_q.size() == 0) begin
          errors++;
          $display("FAIL snap_unexpected: got %h, required no snap_valid",
                   snap_value);
        end else begin
          es = snap_q.pop_front();
          if (snap_value !== es) begin
            errors++;
            $display("FAIL snap_value: got %h, required %h", snap_value, es);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_period = '0; cfg_continuous = 1'b0;
    start_req = 1'b0; stop_req = 1'b0; snap_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, required 0", busy);
    end
    checks++;
    if (tick_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d, required 0", tick_count);
    end
    checks++;
    if (snap_value !== 32'd0) begin
      errors++; $display("FAIL reset_snap: got %h, required 0", snap_value);
    end
    checks++;
    if ({tick, cfg_err, snap_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 000",
               {tick, cfg_err, snap_valid});
    end
    checks++;
    if ({tm.chipselect, tm.write_n, tm.address, tm.writedata} !==
        {1'b0, 1'b1, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h, required cs=0 wn=1 a=0 d=0",
               tm.chipselect, tm.write_n, tm.address, tm.writedata);
    end
  endtask

  task automatic test_continuous();
    tick_times.delete();
    push_start(100, 1);
    repeat (5) push_op(0, 3'd0, 16'h0);
    do_start(100, 1);
    wait_ticks(5, 700);
    checks++;
    if (tick_times.size() != 5) begin
      errors++;
      $display("FAIL cont_ticks: got %0d, required 5", tick_times.size());
    end
    checks++;
    if (tick_times.size() == 0 ||
        tick_times[0] - t_start != 105 * CLK_NS) begin
      errors++; $display("FAIL cont_first_tick: got %0d ticks or wrong latency, required %0d ns",
                         tick_times.size(), 105 * CLK_NS);
    end
    for (int i = 1; i < tick_times.size(); i++) begin
      checks++;
      if (tick_times[i] - tick_times[i-1] != 100 * CLK_NS) begin
        errors++;
        $display("FAIL cont_interval: got %0t, required %0d ns",
                 tick_times[i] - tick_times[i-1], 100 * CLK_NS);
      end
    end
    checks++;
    if (tick_count !== 16'd5) begin
      errors++; $display("FAIL cont_count: got %0d, required 5", tick_count);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL cont_busy: got %b, required 1", busy);
    end
    do_stop();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_stop: got busy=%b pending=%0d, required 0 0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_one_shot(input logic [31:0] p);
    tick_times.delete();
    push_start(p, 0);
    push_op(0, 3'd0, 16'h0);
    do_start(p, 0);
    wait_ticks(1, int'(p) + 50);
    repeat (200) @(negedge clk);
    checks++;
    if (tick_times.size() != 1) begin
      errors++;
      $display("FAIL oneshot_ticks: got %0d, required 1", tick_times.size());
    end
    checks++;
    if (tick_times.size() == 0 ||
        tick_times[0] - t_start != (longint'(p) + 5) * CLK_NS) begin
      errors++;
      $display("FAIL oneshot_latency: period %0d, required %0d cycles",
               p, p + 5);
    end
    checks++;
    if (busy !== 1'b0 || tick_count !== 16'd1) begin
      errors++;
      $display("FAIL oneshot_end: got busy=%b count=%0d, required 0 1",
               busy, tick_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL oneshot_bus: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_cfg_err();
    logic busy_seen;
    cfg_err_seen = 0;
    busy_seen = 1'b0;
    do_start(8, 1);
    repeat (4) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    checks++;
    if (cfg_err_seen != 1 || busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_8: got pulses=%0d busy=%b, required 1 0",
               cfg_err_seen, busy_seen);
    end
    do_start(15, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (cfg_err_seen != 2) begin
      errors++;
      $display("FAIL cfg_err_15: got pulses=%0d, required 2", cfg_err_seen);
    end
    test_one_shot(16);
    checks++;
    if (cfg_err_seen != 2) begin
      errors++;
      $display("FAIL cfg_err_16: got pulses=%0d, required 2", cfg_err_seen);
    end
  endtask

  task automatic test_stop_pending();
    tick_times.delete();
    push_start(100, 1);
    push_op(0, 3'd1, 16'h0008);
    do_start(100, 1);
    @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (tick_times.size() != 0 || busy !== 1'b0 || tick_count !== 16'd0) begin
      errors++;
      $display("FAIL stop_pend: got ticks=%0d busy=%b count=%0d, required 0 0 0",
               tick_times.size(), busy, tick_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stop_pend_bus: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_snap_run();
    push_start(32'h0002_0000, 1);
    do_start(32'h0002_0000, 1);
    repeat (10) @(negedge clk);
    push_snap();
    snap_q.push_back(32'h0001_2345);
    poke_val = 32'h0001_2345; poke_en = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    poke_en = 1'b0; snap_req = 1'b0;
    wait_snap(20);
    @(negedge clk);
    checks++;
    if (snap_q.size() != 0 || snap_value !== 32'h0001_2345) begin
      errors++;
      $display("FAIL snap_run: got %h pending=%0d, required 00012345 0",
               snap_value, snap_q.size());
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL snap_run_busy: got %b, required 1", busy);
    end
    do_stop();
  endtask

  task automatic test_snap_idle();
    push_snap();
    snap_q.push_back(32'hABCD_0042);
    @(negedge clk);
    poke_val = 32'hABCD_0042; poke_en = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    poke_en = 1'b0; snap_req = 1'b0;
    wait_snap(20);
    repeat (2) @(negedge clk);
    checks++;
    if (snap_q.size() != 0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL snap_idle: got pending=%0d busy=%b bus=%0d, required 0 0 0",
               snap_q.size(), busy, exp_q.size());
    end
  endtask

  task automatic test_irq_snap();
    int guard;
    tick_times.delete();
    push_start(40, 1);
    push_op(0, 3'd0, 16'h0);
    push_snap();
    snap_q.push_back(32'd36);
    do_start(40, 1);
    guard = 0;
    while (tm.irq !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    wait_snap(20);
    @(negedge clk);
    checks++;
    if (snap_q.size() != 0 || tick_times.size() != 1) begin
      errors++;
      $display("FAIL irq_snap: got pending=%0d ticks=%0d, required 0 1",
               snap_q.size(), tick_times.size());
    end
    do_stop();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL irq_snap_bus: got pending=%0d busy=%b, required 0 0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    tick_times.delete();
    push_op(0, 3'd2, 16'h0063);
    push_op(0, 3'd3, 16'h0000);
    do_start(100, 1);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tm.chipselect !== 1'b0 || tm.write_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_abort: got cs=%b wn=%b, required 0 1",
               tm.chipselect, tm.write_n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || snap_value !== 32'd0 || tick_count !== 16'd0 ||
        {tick, cfg_err, snap_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_outputs: got busy=%b snap=%h count=%0d, required 0 0 0",
               busy, snap_value, tick_count);
    end
    checks++;
    if ({tm.chipselect, tm.write_n, tm.address, tm.writedata} !==
        {1'b0, 1'b1, 3'd0, 16'h0}) begin
      errors++;
      $display("FAIL rst_bus: got cs=%b wn=%b a=%0d d=%h, required idle",
               tm.chipselect, tm.write_n, tm.address, tm.writedata);
    end
    reset = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if (tick_times.size() != 0 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got ticks=%0d pending=%0d busy=%b, required 0 0 0",
               tick_times.size(), exp_q.size(), busy);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_continuous();
    test_one_shot(32'h0001_0000);
    test_cfg_err();
    test_stop_pending();
    test_snap_run();
    test_snap_idle();
    test_irq_snap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
